// File: rtl/resp_misr_capture.sv
// Response-side MISR capture: folds the observed output vector into a signature over a programmed window.
// Optional golden compare (golden input, pass output) is enabled by defining RESP_MISR_GOLDEN_EN.
module resp_misr_capture #(
  parameter int unsigned      OUT_W  = 159,
  parameter int unsigned      SIG_W  = 32,
  parameter logic [SIG_W-1:0] POLY   = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED   = 32'hFFFFFFFF,
  parameter int unsigned      CNT_W  = 16,
  parameter int unsigned      SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic             sample_en,
  input  logic [OUT_W-1:0] out_flat,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] samples_taken
`ifdef RESP_MISR_GOLDEN_EN
  , input  logic [SIG_W-1:0] golden
  , output logic             pass
`endif
);

  localparam int unsigned NCH = (OUT_W + SIG_W - 1) / SIG_W;
  localparam int unsigned SW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t             state, state_next;
  logic [SW-1:0]      settle_cnt;
  logic [CNT_W-1:0]   num_q;
  logic [CNT_W-1:0]   samples_inc;
  logic [NCH*SIG_W-1:0] padded;
  logic [SIG_W-1:0]   fold;
  logic [SIG_W-1:0]   sig_next;
  logic               accept_start;
  logic               take_sample;

`ifdef RESP_MISR_GOLDEN_EN
  logic [SIG_W-1:0]   golden_q;
`endif

  always_comb begin
    padded = '0;
    padded[OUT_W-1:0] = out_flat;
    fold = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      fold = fold ^ padded[i*SIG_W +: SIG_W];
    end
    sig_next = {signature[SIG_W-2:0], 1'b0} ^ (signature[SIG_W-1] ? POLY : '0) ^ fold;
  end

  assign samples_inc  = samples_taken + CNT_W'(1);
  assign accept_start = (state == ST_IDLE) && start;
  // abort wins over a coincident sample, so the partial signature is left untouched
  assign take_sample  = (state == ST_CAPTURE) && sample_en && !abort;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (num_cycles == '0)  state_next = ST_DONE;
          else if (SETTLE == 0)  state_next = ST_CAPTURE;
          else                   state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort)                            state_next = ST_IDLE;
        else if (settle_cnt == SETTLE_LAST)   state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (abort)                                   state_next = ST_IDLE;
        else if (sample_en && (samples_inc == num_q)) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_SETTLE) || (state == ST_CAPTURE);
    done = (state == ST_DONE);
`ifdef RESP_MISR_GOLDEN_EN
    pass = (state == ST_DONE) && (signature == golden_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n || (state != ST_SETTLE)) begin
      settle_cnt <= '0;
    end else begin
      settle_cnt <= settle_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      signature     <= '0;
      samples_taken <= '0;
      num_q         <= '0;
`ifdef RESP_MISR_GOLDEN_EN
      golden_q      <= '0;
`endif
    end else if (accept_start) begin
      signature     <= SEED;
      samples_taken <= '0;
      num_q         <= num_cycles;
`ifdef RESP_MISR_GOLDEN_EN
      golden_q      <= golden;
`endif
    end else if (take_sample) begin
      signature     <= sig_next;
      samples_taken <= samples_inc;
    end
  end

endmodule

// File: tb/tb_resp_misr_capture.sv
// Directed scoreboard bench for resp_misr_capture; golden/pass checks are included when RESP_MISR_GOLDEN_EN is defined.
module tb_resp_misr_capture;

  localparam int OUT_W  = 159;
  localparam int SIG_W  = 32;
  localparam int CNT_W  = 16;
  localparam int SETTLE = 2;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] num_cycles;
  logic             sample_en;
  logic [OUT_W-1:0] out_flat;
  logic             busy;
  logic             done;
  logic [SIG_W-1:0] signature;
  logic [CNT_W-1:0] samples_taken;
`ifdef RESP_MISR_GOLDEN_EN
  logic [SIG_W-1:0] golden;
  logic             pass;
`endif

  typedef struct {
    logic [31:0] sig;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   busy_cycles;
  int   done_pulses;

  always #5 clk = ~clk;

  resp_misr_capture #(
    .OUT_W (OUT_W),
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED),
    .CNT_W (CNT_W),
    .SETTLE(SETTLE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .num_cycles   (num_cycles),
    .sample_en    (sample_en),
    .out_flat     (out_flat),
    .busy         (busy),
    .done         (done),
    .signature    (signature),
    .samples_taken(samples_taken)
`ifdef RESP_MISR_GOLDEN_EN
    , .golden     (golden)
    , .pass       (pass)
`endif
  );

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cycles++;
    if (done === 1'b1) done_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference fold: bit i of the vector lands in signature lane i mod SIG_W
  function automatic logic [31:0] ref_fold(input logic [OUT_W-1:0] v);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < OUT_W; i++) f[i % SIG_W] = f[i % SIG_W] ^ v[i];
    return f;
  endfunction

  function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [31:0] f);
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

  function automatic logic [OUT_W-1:0] rnd_vec();
    logic [OUT_W-1:0] v;
    v = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return v;
  endfunction

  // One window: start, SETTLE cycles with noisy sample_en, then capture driven from en_bits.
  task automatic run_window(input string tag, input logic [15:0] n, input logic [31:0] gold,
                            input logic [31:0] en_bits, input logic [OUT_W-1:0] data,
                            input bit rnd_data, input int abort_at, input logic poke_start,
                            output logic [31:0] sig_out);
    logic [31:0] msig;
    logic [15:0] mcnt;
    bit          aborted;
    int          k;
    exp_t        e;
    exp_t        got;
    msig = SEED;
    mcnt = '0;
    aborted = 0;
    k = 0;
    busy_cycles = 0;
    done_pulses = 0;
    start = 1'b1;
    num_cycles = n;
    sample_en = 1'b1;
    out_flat = data;
`ifdef RESP_MISR_GOLDEN_EN
    golden = gold;
`endif
    tick();
    start = poke_start;
    num_cycles = n ^ 16'h00F0;
`ifdef RESP_MISR_GOLDEN_EN
    golden = ~gold;
`endif
    if (n != 0) begin
      chk({tag, "/busy_on"}, {31'b0, busy}, 32'd1);
      for (int i = 0; i < SETTLE; i++) begin
        sample_en = 1'b1;
        out_flat = rnd_vec();
        tick();
      end
      chk({tag, "/settle_no_sample"}, {16'b0, samples_taken}, 32'd0);
      for (int i = 0; i < 32 && mcnt < n && !aborted; i++) begin
        sample_en = en_bits[i];
        out_flat = (rnd_data && i > 0) ? rnd_vec() : data;
        abort = (i == abort_at);
        tick();
        k++;
        if (abort) aborted = 1;
        else if (sample_en) begin
          msig = ref_step(msig, ref_fold(out_flat));
          mcnt++;
        end
        abort = 1'b0;
      end
    end
    start = 1'b0;
    sample_en = 1'b0;
    e.sig = msig;
    e.cnt = mcnt;
    sb.push_back(e);
    if (aborted) begin
      chk({tag, "/abort_busy"}, {31'b0, busy}, 32'd0);
      chk({tag, "/abort_done"}, {31'b0, done}, 32'd0);
    end else begin
      chk({tag, "/done"}, {31'b0, done}, 32'd1);
`ifdef RESP_MISR_GOLDEN_EN
      chk({tag, "/pass"}, {31'b0, pass}, {31'b0, (msig == gold)});
`endif
    end
    got = sb.pop_front();
    chk({tag, "/signature"}, signature, got.sig);
    chk({tag, "/samples"}, {16'b0, samples_taken}, {16'b0, got.cnt});
    tick();
    chk({tag, "/idle_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "/idle_done"}, {31'b0, done}, 32'd0);
    chk({tag, "/sig_hold"}, signature, got.sig);
    chk({tag, "/done_pulses"}, done_pulses, aborted ? 32'd0 : 32'd1);
    chk({tag, "/busy_cycles"}, busy_cycles, (n == 0) ? 32'd0 : 32'(SETTLE + k));
    sig_out = msig;
  endtask

  logic [31:0] s;

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    num_cycles = 16'd4;
    sample_en = 1'b1;
    out_flat = '1;
`ifdef RESP_MISR_GOLDEN_EN
    golden = '0;
`endif
    tick();
    tick();
    chk("reset/busy", {31'b0, busy}, 32'd0);
    chk("reset/done", {31'b0, done}, 32'd0);
    chk("reset/signature", signature, 32'd0);
    chk("reset/samples", {16'b0, samples_taken}, 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    sample_en = 1'b0;
    tick();

    run_window("single_zero", 16'd1, 32'hFB3EE249, 32'h1, '0, 0, -1, 1'b0, s);
    chk("single_zero/const", s, 32'hFB3EE249);
    chk("single_zero/busy3", busy_cycles, 32'd3);

    run_window("fold_ones", 16'd1, 32'h0, 32'h1, '1, 0, -1, 1'b0, s);
    chk("fold_ones/fold", ref_fold('1), 32'h7FFFFFFF);
    chk("fold_ones/const", s, 32'h84C11DB6);

    run_window("stall", 16'd3, 32'h0, 32'b11001, '0, 0, -1, 1'b0, s);
    chk("stall/const", s, ref_step(ref_step(ref_step(SEED, 32'h0), 32'h0), 32'h0));

    run_window("zero_win", 16'd0, SEED, 32'h0, '0, 0, -1, 1'b0, s);

    run_window("poke_start", 16'd6, 32'h0, 32'hFFFF_FFFF, rnd_vec(), 1, -1, 1'b1, s);

    run_window("abort", 16'd5, 32'h0, 32'hFFFF_FFFF, rnd_vec(), 1, 2, 1'b0, s);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort/busy", {31'b0, busy}, 32'd0);
    chk("idle_abort/signature", signature, s);
    chk("idle_abort/samples", {16'b0, samples_taken}, 32'd2);

    run_window("random_gaps", 16'd7, 32'h0, 32'hA5B3_6D5F, rnd_vec(), 1, -1, 1'b0, s);

    start = 1'b1;
    num_cycles = 16'd5;
    sample_en = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sample_en = 1'b0;
    chk("mid_reset/busy", {31'b0, busy}, 32'd0);
    chk("mid_reset/signature", signature, 32'd0);
    chk("mid_reset/samples", {16'b0, samples_taken}, 32'd0);
    tick();
    chk("mid_reset/stay_idle", {31'b0, busy}, 32'd0);

`ifdef RESP_MISR_GOLDEN_EN
    run_window("golden_bad", 16'd1, 32'h0, 32'h1, '0, 0, -1, 1'b0, s);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
